// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM and its read pipe.
// Latency: none (types, constants and a combinational merge function only).
// Backpressure: not applicable.
package ram_pkg;

  // Controller state: zeroing sweep after reset, then normal service.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // Same-address read/write policy selectors.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest data word the merge helper handles; users check against it.
  localparam int MERGE_MAX_W = 512;
  localparam int MERGE_IW    = $clog2(MERGE_MAX_W);

  // Byte-lane merge: bits of lanes whose enable is set come from new_w,
  // all other bits keep old_w. Callers zero-extend into and truncate out of
  // the fixed-width container; byte_w is a constant at every call site.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] be,
    input int unsigned            byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int unsigned k = 0; k < MERGE_MAX_W; k++) begin
      if (be[MERGE_IW'(k / byte_w)]) begin
        res[k] = new_w[k];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return delay line carrying the read strobe and word through LAT stages.
// Latency: exactly LAT cycles from vld_i to vld_o.
// Backpressure: none; accepts a new entry every cycle, each data stage loads only on its strobe so the output holds the last returned word.
module ram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);

  logic [LAT-1:0]    vld_q;
  logic [DATA_W-1:0] dat_q [LAT];

  // Shift the strobe every cycle; advance data only behind a valid strobe.
  // Reset drops in-flight strobes at once and clears any stale word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        dat_q[0] <= dat_i;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign dat_o = dat_q[LAT-1];

endmodule

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency, RDW policy and post-reset zeroing sweep.
// Latency: rd_valid/rd_data follow an accepted read by RD_LAT cycles; init_done rises DEPTH cycles after reset release.
// Backpressure: none; one read and one write per cycle once ready, requests during the sweep are dropped and flagged.
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_done,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     oe,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     access_err,
  input  logic                     err_clr
);

  // Parameter legality, caught at elaboration.
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("ram_sdp_param: RD_LAT must be 1 or 2");
  end
  if (BYTE_W < 1 || (DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
    $error("ram_sdp_param: DATA_W must be a multiple of BYTE_W");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("ram_sdp_param: DEPTH must be in 1..2**ADDR_W");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("ram_sdp_param: RDW_MODE must be 0 or 1");
  end
  if (DATA_W > MERGE_MAX_W) begin : g_bad_data_w
    $error("ram_sdp_param: DATA_W exceeds byte_merge container width");
  end

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  // Storage has no reset; the sweep below provides the known-zero state.
  logic [DATA_W-1:0] mem_q [DEPTH];

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              access_err_q, access_err_d;

  logic              is_ready;
  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc, rd_hit;
  logic              same_addr;
  logic              err_set;
  logic [DATA_W-1:0] rd_old, rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_dat;

  assign is_ready    = (state_q == ST_READY);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Writes only land in range; reads always return a strobe once ready,
  // but an out-of-range read returns zero instead of touching the array.
  assign wr_acc    = is_ready & wr_en & wr_in_range;
  assign rd_acc    = is_ready & rd_en;
  assign rd_hit    = rd_acc & rd_in_range;
  assign same_addr = wr_acc & rd_hit & (wr_addr == rd_addr);

  // Error sources: any request during the sweep, or an out-of-range address.
  assign err_set = (~is_ready & (wr_en | rd_en))
                 | (is_ready & wr_en & ~wr_in_range)
                 | (is_ready & rd_en & ~rd_in_range);

  // Array read with the same-address policy applied for the write-first mode.
  always_comb begin
    rd_old  = '0;
    rd_word = '0;
    if (rd_in_range) begin
      rd_old = mem_q[rd_addr];
    end
    if (rd_hit) begin
      rd_word = rd_old;
      if (RDW_MODE == RDW_NEW && same_addr) begin
        rd_word = DATA_W'(byte_merge(MERGE_MAX_W'(rd_old), MERGE_MAX_W'(wr_data),
                                     MERGE_MAX_W'(wr_be), BYTE_W));
      end
    end
  end

  // Single array write port shared by the clear sweep and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
      mem_wdata = DATA_W'(byte_merge(MERGE_MAX_W'(mem_q[wr_addr]), MERGE_MAX_W'(wr_data),
                                     MERGE_MAX_W'(wr_be), BYTE_W));
    end
  end

  // Array update; lanes with wr_be clear were already folded back in above.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Sweep sequencing: one zero write per cycle, leave CLEAR after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Sticky error flag; a new error wins over a clear in the same cycle.
  always_comb begin
    access_err_d = access_err_q;
    if (err_clr) begin
      access_err_d = 1'b0;
    end
    if (err_set) begin
      access_err_d = 1'b1;
    end
  end

  // Controller and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      access_err_q <= access_err_d;
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (rd_acc),
    .dat_i  (rd_word),
    .vld_o  (pipe_vld),
    .dat_o  (pipe_dat)
  );

  assign init_done  = is_ready;
  assign rd_valid   = pipe_vld;
  assign rd_data    = oe ? pipe_dat : '0;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: instance A uses defaults (DEPTH 256, RD_LAT 1, old-data RDW),
// instance B uses DEPTH 200, RD_LAT 2, write-first RDW. Both share all inputs.
// Cycle vectors are checked 1 ns after each rising edge.
module tb_ram_sdp_param;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int   NV = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, rd_en, oe, err_clr;
  logic [7:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        a_init, a_vld, a_err, b_init, b_vld, b_err;
  logic [15:0] a_dat, b_dat;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int na, nb, stray, rel, ac, bc, a_bad, b_bad;
  logic [15:0] ref_w [10];

  ram_sdp_param dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .oe(oe), .rd_data(a_dat), .rd_valid(a_vld),
    .access_err(a_err), .err_clr(err_clr)
  );

  ram_sdp_param #(.DEPTH(200), .RD_LAT(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .oe(oe), .rd_data(b_dat), .rd_valid(b_vld),
    .access_err(b_err), .err_clr(err_clr)
  );

  typedef struct packed {
    logic we; logic [7:0] wa; logic [1:0] be; logic [15:0] wd;
    logic re; logic [7:0] ra; logic oe; logic clr;
    logic a_v; logic [15:0] a_d; logic a_e;
    logic b_v; logic [15:0] b_d; logic b_e;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t v(
    input logic we, input logic [7:0] wa, input logic [1:0] be, input logic [15:0] wd,
    input logic re, input logic [7:0] ra, input logic o, input logic clr,
    input logic a_v, input logic [15:0] a_d, input logic a_e,
    input logic b_v, input logic [15:0] b_d, input logic b_e);
    vec_t r;
    r = '{we:we, wa:wa, be:be, wd:wd, re:re, ra:ra, oe:o, clr:clr,
          a_v:a_v, a_d:a_d, a_e:a_e, b_v:b_v, b_d:b_d, b_e:b_e};
    return r;
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Counts cycles from 'start' until each instance reports init_done; bounded.
  task automatic wait_init(input int start, output int ra_n, output int rb_n, output int st);
    ra_n = -1; rb_n = -1; st = 0;
    while ((ra_n < 0 || rb_n < 0) && (cyc - start) < 400) begin
      tick();
      if (a_vld || b_vld) st++;
      if (a_init && ra_n < 0) ra_n = cyc - start;
      if (b_init && rb_n < 0) rb_n = cyc - start;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; oe = 1'b1; err_clr = 1'b0;

    //          we wa     be     wd        re ra     oe clr  A: v d e            B: v d e
    tbl[0]  = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, H,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[1]  = v(H, 8'd0,  2'b11, 16'h1357, L, 8'd0,  H, L,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[2]  = v(H, 8'd1,  2'b11, 16'h2468, L, 8'd0,  H, L,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[3]  = v(H, 8'd2,  2'b11, 16'hBEEF, L, 8'd0,  H, L,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[4]  = v(H, 8'd3,  2'b11, 16'hA5A5, L, 8'd0,  H, L,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[5]  = v(H, 8'd3,  2'b01, 16'h1234, H, 8'd0,  H, L,   H, 16'h1357, L,   L, 16'h0000, L);
    tbl[6]  = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd1,  H, L,   H, 16'h2468, L,   H, 16'h1357, L);
    tbl[7]  = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd3,  H, L,   H, 16'hA534, L,   H, 16'h2468, L);
    tbl[8]  = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd2,  L, L,   H, 16'h0000, L,   H, 16'h0000, L);
    tbl[9]  = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'hBEEF, L,   H, 16'hBEEF, L);
    tbl[10] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'hBEEF, L,   L, 16'hBEEF, L);
    tbl[11] = v(H, 8'd7,  2'b11, 16'h1111, L, 8'd0,  H, L,   L, 16'hBEEF, L,   L, 16'hBEEF, L);
    tbl[12] = v(H, 8'd7,  2'b11, 16'h2222, H, 8'd7,  H, L,   H, 16'h1111, L,   L, 16'hBEEF, L);
    tbl[13] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'h1111, L,   H, 16'h2222, L);
    tbl[14] = v(H, 8'd7,  2'b10, 16'hABCD, H, 8'd7,  H, L,   H, 16'h2222, L,   L, 16'h2222, L);
    tbl[15] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd7,  H, L,   H, 16'hAB22, L,   H, 16'hAB22, L);
    tbl[16] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'hAB22, L,   H, 16'hAB22, L);
    tbl[17] = v(H, 8'd7,  2'b00, 16'hFFFF, L, 8'd0,  H, L,   L, 16'hAB22, L,   L, 16'hAB22, L);
    tbl[18] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd7,  H, L,   H, 16'hAB22, L,   L, 16'hAB22, L);
    tbl[19] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'hAB22, L,   H, 16'hAB22, L);
    tbl[20] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd250,H, L,   H, 16'h0000, L,   L, 16'hAB22, H);
    tbl[21] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'h0000, L,   H, 16'h0000, H);
    tbl[22] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, H,   L, 16'h0000, L,   L, 16'h0000, L);
    tbl[23] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd220,H, H,   H, 16'h0000, L,   L, 16'h0000, H);
    tbl[24] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, H,   L, 16'h0000, L,   H, 16'h0000, L);
    tbl[25] = v(H, 8'd210,2'b11, 16'h5555, L, 8'd0,  H, L,   L, 16'h0000, L,   L, 16'h0000, H);
    tbl[26] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd210,H, L,   H, 16'h5555, L,   L, 16'h0000, H);
    tbl[27] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'h5555, L,   H, 16'h0000, H);
    tbl[28] = v(H, 8'd199,2'b11, 16'h7777, L, 8'd0,  H, H,   L, 16'h5555, L,   L, 16'h0000, L);
    tbl[29] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd199,H, L,   H, 16'h7777, L,   L, 16'h0000, L);
    tbl[30] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'h7777, L,   H, 16'h7777, L);
    tbl[31] = v(H, 8'd255,2'b11, 16'h0F0F, L, 8'd0,  H, L,   L, 16'h7777, L,   L, 16'h7777, H);
    tbl[32] = v(L, 8'd0,  2'b00, 16'h0000, H, 8'd255,H, L,   H, 16'h0F0F, L,   L, 16'h7777, H);
    tbl[33] = v(L, 8'd0,  2'b00, 16'h0000, L, 8'd0,  H, L,   L, 16'h0F0F, L,   H, 16'h0000, H);

    // Reset values.
    tick(); tick();
    chk_b("rst a_init", a_init, L);  chk_b("rst b_init", b_init, L);
    chk_b("rst a_vld",  a_vld,  L);  chk_b("rst b_vld",  b_vld,  L);
    chk_w("rst a_dat",  a_dat,  16'h0); chk_w("rst b_dat", b_dat, 16'h0);
    chk_b("rst a_err",  a_err,  L);  chk_b("rst b_err",  b_err,  L);

    // Clear sweep length.
    rst_n = 1'b1;
    rel = cyc;
    wait_init(rel, na, nb, stray);
    chk_i("sweep a_cycles", na, 256);
    chk_i("sweep b_cycles", nb, 200);
    chk_i("sweep stray_vld", stray, 0);

    // Back-to-back readback of every address: all zero, one strobe each.
    ac = 0; bc = 0; a_bad = 0; b_bad = 0;
    for (int c = 0; c < 258; c++) begin
      rd_en = (c < 256);
      rd_addr = 8'(c);
      tick();
      if (a_vld) begin ac++; if (a_dat != 16'h0) a_bad++; end
      if (b_vld) begin bc++; if (b_dat != 16'h0) b_bad++; end
    end
    rd_en = 1'b0;
    chk_i("zero a_vld_count", ac, 256);
    chk_i("zero b_vld_count", bc, 256);
    chk_i("zero a_nonzero", a_bad, 0);
    chk_i("zero b_nonzero", b_bad, 0);
    chk_b("zero a_err", a_err, L);
    chk_b("zero b_err_oob", b_err, H);

    // Directed cycle vectors.
    for (int i = 0; i < NV; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra; oe = tbl[i].oe; err_clr = tbl[i].clr;
      tick();
      chk_b($sformatf("row%0d a_vld", i), a_vld, tbl[i].a_v);
      chk_w($sformatf("row%0d a_dat", i), a_dat, tbl[i].a_d);
      chk_b($sformatf("row%0d a_err", i), a_err, tbl[i].a_e);
      chk_b($sformatf("row%0d b_vld", i), b_vld, tbl[i].b_v);
      chk_w($sformatf("row%0d b_dat", i), b_dat, tbl[i].b_d);
      chk_b($sformatf("row%0d b_err", i), b_err, tbl[i].b_e);
    end
    wr_en = 1'b0; rd_en = 1'b0; oe = 1'b1; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Random words to addresses 0..9, read back with oe=1 then oe=0.
    for (int i = 0; i < 10; i++) begin
      ref_w[i] = 16'($urandom_range(1, 65535));
      wr_en = 1'b1; wr_addr = 8'(i); wr_be = 2'b11; wr_data = ref_w[i];
      tick();
    end
    wr_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      oe = (p == 0);
      ac = 0; bc = 0;
      for (int c = 0; c < 12; c++) begin
        rd_en = (c < 10);
        rd_addr = 8'(c);
        tick();
        if (a_vld) ac++;
        if (b_vld) bc++;
        if (c < 10) chk_w($sformatf("rnd p%0d a_dat%0d", p, c), a_dat, oe ? ref_w[c] : 16'h0);
        if (c >= 1 && c < 11) chk_w($sformatf("rnd p%0d b_dat%0d", p, c - 1), b_dat, oe ? ref_w[c-1] : 16'h0);
      end
      chk_i($sformatf("rnd p%0d a_vld_count", p), ac, 10);
      chk_i($sformatf("rnd p%0d b_vld_count", p), bc, 10);
    end
    rd_en = 1'b0; oe = 1'b1;
    chk_b("rnd a_err", a_err, L);
    chk_b("rnd b_err", b_err, L);

    // Reset with reads in flight.
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    rd_addr = 8'd1;
    tick();
    rd_en = 1'b0;
    chk_b("inflight a_vld", a_vld, H);
    chk_b("inflight b_vld", b_vld, H);
    #2 rst_n = 1'b0;
    #1;
    chk_b("midrst a_vld", a_vld, L);  chk_b("midrst b_vld", b_vld, L);
    chk_w("midrst a_dat", a_dat, 16'h0); chk_w("midrst b_dat", b_dat, 16'h0);
    chk_b("midrst a_init", a_init, L); chk_b("midrst b_init", b_init, L);
    tick(); tick();

    // Requests during the sweep are ignored but flagged.
    rst_n = 1'b1;
    rel = cyc;
    rd_en = 1'b1; rd_addr = 8'd5;
    wr_en = 1'b1; wr_addr = 8'd4; wr_be = 2'b11; wr_data = 16'hDEAD;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk_b("clear a_err", a_err, H);   chk_b("clear b_err", b_err, H);
    chk_b("clear a_vld", a_vld, L);   chk_b("clear b_vld", b_vld, L);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_b("clear a_errclr", a_err, L); chk_b("clear b_errclr", b_err, L);
    chk_b("clear b_vld2", b_vld, L);
    wait_init(rel, na, nb, stray);
    chk_i("resweep a_cycles", na, 256);
    chk_i("resweep b_cycles", nb, 200);
    chk_i("resweep stray_vld", stray, 0);
    chk_w("resweep a_dat", a_dat, 16'h0);
    chk_w("resweep b_dat", b_dat, 16'h0);

    // Prior contents are gone: address 0 held a nonzero word before reset.
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    chk_b("post a_vld", a_vld, H);
    chk_w("post a_dat", a_dat, 16'h0);
    chk_b("post b_vld_early", b_vld, L);
    tick();
    chk_b("post b_vld", b_vld, H);
    chk_w("post b_dat", b_dat, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_sdp_param.md
Name: ram_sdp_param

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on a single clock. Adds byte-enable writes, selectable read latency (1 or 2 cycles) with a read-valid strobe, and a selectable read-during-write policy. A post-reset clear sequencer zeroes every location before the block reports ready. Output-enable gating is retained for drop-in use as a generic on-chip buffer or register store.

Parameters:
DATA_W, 16, data word width; must be a multiple of BYTE_W.
BYTE_W, 8, bits per byte-enable lane.
ADDR_W, 8, address width.
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
RDW_MODE, 0, same-address read/write in one cycle; 0 = old data, 1 = new (write-first, byte-merged) data.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
init_done  output  1  high once the clear sweep has finished
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_be  input  DATA_W/BYTE_W  byte enables; lane k covers bits [k*BYTE_W +: BYTE_W]
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
oe  input  1  output enable; combinational gate on rd_data
rd_data  output  DATA_W  read data; all zeros when oe=0
rd_valid  output  1  pulses RD_LAT cycles after an accepted read
access_err  output  1  sticky error flag
err_clr  input  1  synchronous clear of access_err

Behaviour:
- Reset values: init_done=0, rd_valid=0, internal read register=0, access_err=0, clear counter=0, FSM in CLEAR. The memory array has no reset.
- FSM states:
  - CLEAR: write 0 to address cnt each cycle; cnt increments; when cnt==DEPTH-1 the write completes and the FSM moves to READY. The sweep takes exactly DEPTH cycles after rst_n deasserts. init_done rises on the first READY cycle.
  - READY: normal operation. No exit except reset.
- Requests during CLEAR: wr_en/rd_en are ignored, no rd_valid is produced, and access_err is set.
- Write (READY): at a clock edge with wr_en=1 and wr_addr<DEPTH, lanes with wr_be[k]=1 are updated; other lanes keep their contents. wr_be=0 is a legal no-op.
- Read (READY): rd_en=1 and rd_addr<DEPTH reads mem[rd_addr].
  - RD_LAT=1: data is registered and rd_valid=1 on the next cycle.
  - RD_LAT=2: an additional output register stage; rd_valid follows two cycles after the request.
  - Back-to-back reads are allowed every cycle (fully pipelined).
- rd_data holds the last read value until the next valid read updates it. The oe gating does not affect the registers or rd_valid.
- Out-of-range address (>= DEPTH), either port:
  - write: dropped;
  - read: rd_valid is still produced with data 0;
  - both cases set access_err.
- Same-address read and write in one cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the write-first, byte-merged word (new lanes where wr_be=1, old lanes elsewhere).
  - Different addresses are independent.
- access_err: set has priority over err_clr in the same cycle.
- Reset mid-operation: in-flight reads are discarded (rd_valid=0 immediately, asynchronously). After deassert, CLEAR reruns from address 0 and prior contents are lost.
- Illegal parameters (RD_LAT not 1 or 2, DATA_W%BYTE_W!=0, DEPTH>2**ADDR_W) are flagged by an elaboration-time $error.

Decomposition:
- Shared package ram_pkg holds the FSM state enum (ST_CLEAR, ST_READY), the RDW_OLD/RDW_NEW constants, and a byte-merge function (old, new, be).
- One natural sub-module: ram_rd_pipe, the parametrised RD_LAT valid/data delay line with asynchronous reset.
- The array, write-lane logic and FSM stay in the top level.

Test Plan:
- Reset, clear sweep: release rst_n with DEPTH=256, hold wr_en=rd_en=0 -> init_done rises exactly 256 cycles after deassert. Then read addresses 0..255 -> all return 16'h0000 with rd_valid each.
- Randomised write/readback: write 10 random words to addresses 0..9 with wr_be=2'b11, read back with oe=1 -> every rd_data matches its reference, rd_valid count is 10, access_err=0. Repeat with oe=0 -> rd_data=0 while rd_valid still pulses.
- Byte enables: write 16'hA5A5 to addr 3, then 16'h1234 with wr_be=2'b01 -> read returns 16'hA534.
- Read-during-write and latency: with mem[7]=16'h1111, write 16'h2222 to addr 7 and read addr 7 in the same cycle.
  - RDW_MODE=0 returns 16'h1111; RDW_MODE=1 returns 16'h2222.
  - Check for RD_LAT=1 and 2: rd_valid appears 1 and 2 cycles after the request respectively.
- Errors and mid-operation reset:
  - Access during CLEAR -> access_err=1; pulse err_clr -> 0.
  - DEPTH=200: read addr 250 -> data 0, rd_valid=1, access_err=1.
  - Assert rst_n low with two reads in flight -> rd_valid drops immediately, no stale data after release, and the sweep restarts.
